// File: rtl/asic_unlock_seq_detector.sv
// asic_unlock_seq_detector: watches &BCxx port writes for the 17-byte Plus ASIC unlock sequence
module asic_unlock_seq_detector #(
  parameter logic [7:0] ADDR_HI_MASK  = 8'hFF,
  parameter logic [7:0] ADDR_HI_MATCH = 8'hBC,
  parameter logic [7:0] UNLOCK_BYTE   = 8'hEE
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        plus_mode,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        io_wr,
  output logic        asic_unlocked,
  output logic        unlock_pulse,
  output logic        lock_pulse,
  output logic [3:0]  seq_index,
  output logic [2:0]  fsm_state
);
  typedef enum logic [2:0] {HUNT = 3'd0, SYNC_NZ = 3'd1, SYNC_Z = 3'd2, MATCH = 3'd3, FINAL = 3'd4} state_t;
  localparam logic [13:0][7:0] TBL = {8'hCD, 8'h8A, 8'h15, 8'h2B, 8'h46, 8'h9C, 8'h39,
                                      8'h62, 8'hD4, 8'hA8, 8'h51, 8'hB3, 8'h77, 8'hFF};
  state_t     state_q, state_d, miss_state;
  logic [3:0] idx_q, idx_d;
  logic       unl_q, unl_d, up_q, up_d, lp_q, lp_d, io_wr_q, ev, nz;
  logic       addr_lo_unused;
  assign addr_lo_unused = ^cpu_addr[7:0];
  assign ev = io_wr & ~io_wr_q & ((cpu_addr[15:8] & ADDR_HI_MASK) == ADDR_HI_MATCH);
  assign nz = |cpu_data;
  // a zero byte after any non-zero byte is a valid sync pair, so mismatches can re-sync at once
  assign miss_state = nz ? SYNC_NZ : SYNC_Z;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unl_d   = unl_q;
    up_d    = 1'b0;
    lp_d    = 1'b0;
    if (ev) begin
      case (state_q)
        HUNT:    state_d = nz ? SYNC_NZ : HUNT;
        SYNC_NZ: state_d = nz ? SYNC_NZ : SYNC_Z;
        SYNC_Z, MATCH: begin
          if (cpu_data == TBL[idx_q]) begin
            state_d = (idx_q == 4'd13) ? FINAL : MATCH;
            idx_d   = (idx_q == 4'd13) ? idx_q : idx_q + 4'd1;
          end else begin
            state_d = miss_state;
            idx_d   = 4'd0;
          end
        end
        FINAL: begin
          state_d = miss_state;
          idx_d   = 4'd0;
          unl_d   = cpu_data == UNLOCK_BYTE;
          up_d    = cpu_data == UNLOCK_BYTE;
          lp_d    = cpu_data != UNLOCK_BYTE && unl_q;
        end
        default: state_d = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk_sys) begin
    if (reset || !plus_mode) begin
      state_q <= HUNT;
      idx_q   <= 4'd0;
      unl_q   <= 1'b0;
      up_q    <= 1'b0;
      lp_q    <= 1'b0;
      io_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      unl_q   <= unl_d;
      up_q    <= up_d;
      lp_q    <= lp_d;
      io_wr_q <= io_wr;
    end
  end
  assign asic_unlocked = unl_q;
  assign unlock_pulse  = up_q;
  assign lock_pulse    = lp_q;
  assign seq_index     = idx_q;
  assign fsm_state     = state_q;
endmodule

// File: tb/tb_asic_unlock_seq_detector.sv
// tb_asic_unlock_seq_detector: scoreboard bench; each write queues the outputs expected after it
module tb_asic_unlock_seq_detector;
  logic        clk_sys = 1'b0;
  logic        reset, plus_mode, io_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        asic_unlocked, unlock_pulse, lock_pulse;
  logic [3:0]  seq_index;
  logic [2:0]  fsm_state;

  asic_unlock_seq_detector dut (
    .clk_sys(clk_sys), .reset(reset), .plus_mode(plus_mode), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .io_wr(io_wr), .asic_unlocked(asic_unlocked),
    .unlock_pulse(unlock_pulse), .lock_pulse(lock_pulse), .seq_index(seq_index),
    .fsm_state(fsm_state)
  );

  always #5 clk_sys = ~clk_sys;

  localparam logic [2:0] HUNT = 3'd0, SNZ = 3'd1, SZ = 3'd2, MT = 3'd3, FN = 3'd4;
  logic [7:0] tbl [14] = '{8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                           8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD};

  typedef struct {string tag; logic [9:0] exp; int due;} sb_t;
  sb_t  sb[$];
  int   cyc = 0, n_run = 0, n_fail = 0;
  logic cu = 1'b0;
  wire [9:0] obs = {asic_unlocked, unlock_pulse, lock_pulse, fsm_state, seq_index};

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {unl,up,lp,st,idx}=%b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] pk(input logic u, input logic up, input logic lp,
                                    input logic [2:0] st, input logic [3:0] idx);
    return {u, up, lp, st, idx};
  endfunction

  task automatic push(input string tag, input logic [9:0] e, input int due);
    sb_t s;
    s.tag = tag; s.exp = e; s.due = due;
    sb.push_back(s);
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys)
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      check(sb[0].tag, obs, sb[0].exp);
      void'(sb.pop_front());
    end

  task automatic idle_chk(input string tag, input logic [9:0] e);
    push(tag, e, cyc + 1);
    @(negedge clk_sys);
  endtask

  // outputs checked the cycle after the strobe edge, and again one cycle later with pulses gone
  task automatic wr(input logic [7:0] d, input logic [15:0] a, input int hold,
                    input logic [9:0] e, input string tag);
    push(tag, e, cyc + 1);
    push({tag, "+1"}, e & ~10'h180, cyc + 2);
    io_wr = 1'b1; cpu_addr = a; cpu_data = d;
    repeat (hold) @(negedge clk_sys);
    io_wr = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic b(input logic [7:0] d, input logic [2:0] st, input logic [3:0] idx, input string tag);
    wr(d, 16'hBC00 + 16'(d), 1, pk(cu, 1'b0, 1'b0, st, idx), tag);
  endtask

  task automatic other(input int hold, input logic [2:0] st, input logic [3:0] idx);
    wr(8'h00, 16'h7FBC, hold, pk(cu, 1'b0, 1'b0, st, idx), "io7f");
  endtask

  task automatic sync(input int hold, input bit inter);
    wr(8'hFF, 16'hBC00, hold, pk(cu, 1'b0, 1'b0, SNZ, 4'd0), "sync_nz");
    if (inter) other(hold, SNZ, 4'd0);
    wr(8'h00, 16'hBC00, hold, pk(cu, 1'b0, 1'b0, SZ, 4'd0), "sync_z");
    if (inter) other(hold, SZ, 4'd0);
  endtask

  task automatic body(input int n, input int hold, input bit inter);
    for (int i = 0; i < n; i++) begin
      logic [2:0] st;
      logic [3:0] idx;
      st  = (i == 13) ? FN : MT;
      idx = (i == 13) ? 4'd13 : 4'(i + 1);
      wr(tbl[i], 16'hBC00 + 16'(i), hold, pk(cu, 1'b0, 1'b0, st, idx), $sformatf("t%0d", i));
      if (inter) other(hold, st, idx);
    end
  endtask

  task automatic fin(input logic [7:0] d, input int hold, input string tag);
    logic nu, lp;
    nu = (d == 8'hEE);
    lp = !nu && cu;
    wr(d, 16'hBC7F, hold, pk(nu, nu, lp, (d == 8'h00) ? SZ : SNZ, 4'd0), tag);
    cu = nu;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; plus_mode = 1'b1; io_wr = 1'b0; cpu_addr = '0; cpu_data = '0;
    repeat (3) @(negedge clk_sys);
    idle_chk("reset_state", pk(1'b0, 1'b0, 1'b0, HUNT, 4'd0));
    reset = 1'b0;
    idle_chk("after_reset", pk(1'b0, 1'b0, 1'b0, HUNT, 4'd0));
    b(8'h00, HUNT, 4'd0, "hunt_zero");
    // 1: plain unlock
    sync(1, 1'b0); body(14, 1, 1'b0); fin(8'hEE, 1, "unlock1");
    // 2: bad final byte locks, good one relocks, EE while unlocked pulses again
    sync(1, 1'b0); body(14, 1, 1'b0); fin(8'hA5, 1, "lock_a5");
    sync(1, 1'b0); body(14, 1, 1'b0); fin(8'hEE, 1, "relock");
    sync(1, 1'b0); body(14, 1, 1'b0); fin(8'hEE, 1, "unlock_again");
    b(8'h00, SZ, 4'd0, "mm_sz");
    b(8'h12, SNZ, 4'd0, "mm_keeps_unlocked");
    // 3: zero mid-match re-syncs directly
    sync(1, 1'b0); body(14, 1, 1'b0); fin(8'h5A, 1, "lock_5a");
    sync(1, 1'b0);
    b(8'hFF, MT, 4'd1, "r_ff"); b(8'h77, MT, 4'd2, "r_77"); b(8'h00, SZ, 4'd0, "resync");
    body(14, 1, 1'b0); fin(8'hEE, 1, "unlock_resync");
    // 4: long strobes interleaved with other-port writes
    sync(5, 1'b1); body(14, 5, 1'b1); fin(8'hA5, 5, "lock_long");
    sync(5, 1'b1); body(14, 5, 1'b1); fin(8'hEE, 5, "unlock_long");
    // 5: reset at seq_index 9 while unlocked
    sync(1, 1'b0); body(9, 1, 1'b0);
    reset = 1'b1;
    idle_chk("mid_reset", pk(1'b0, 1'b0, 1'b0, HUNT, 4'd0));
    reset = 1'b0; cu = 1'b0;
    idle_chk("mid_reset_rel", pk(1'b0, 1'b0, 1'b0, HUNT, 4'd0));
    sync(1, 1'b0); body(14, 1, 1'b0); fin(8'hEE, 1, "unlock_post_reset");
    sync(1, 1'b0); body(9, 1, 1'b0);
    plus_mode = 1'b0; cu = 1'b0;
    idle_chk("plus_off", pk(1'b0, 1'b0, 1'b0, HUNT, 4'd0));
    b(8'hFF, HUNT, 4'd0, "plus_off_wr");
    plus_mode = 1'b1;
    sync(1, 1'b0); body(14, 1, 1'b0); fin(8'hEE, 1, "unlock_post_plus");
    // 6: final 00 while locked gives sync without pulses
    sync(1, 1'b0); body(14, 1, 1'b0); fin(8'hA5, 1, "lock6");
    sync(1, 1'b0); body(14, 1, 1'b0); fin(8'h00, 1, "final_zero");
    body(14, 1, 1'b0); fin(8'hEE, 1, "unlock_nosync");
    repeat (2) @(negedge clk_sys);
    check("sb_drain", 10'(sb.size()), 10'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
